// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 32-GPR processor: opcodes, IR field
// positions and the instruction-fetch state encoding.
package cpu_pkg;

    localparam int IR_W = 32;

    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_NOR  = 5'd10;
    localparam logic [4:0] OP_NOT  = 5'd11;
    localparam logic [4:0] OP_HALT = 5'd31;

    // IR layout; rsrc2 and isrc overlap, imm_mode selects which one is meant.
    localparam int OPER_MSB     = 31;
    localparam int OPER_LSB     = 27;
    localparam int RDST_MSB     = 26;
    localparam int RDST_LSB     = 22;
    localparam int RSRC1_MSB    = 21;
    localparam int RSRC1_LSB    = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RSRC2_MSB    = 15;
    localparam int RSRC2_LSB    = 11;
    localparam int ISRC_MSB     = 15;
    localparam int ISRC_LSB     = 0;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_FETCH  = 3'd1,
        FS_WAIT   = 3'd2,
        FS_HOLD   = 3'd3,
        FS_HALTED = 3'd4
    } fetch_state_e;

    function automatic logic [4:0] ir_oper(input logic [IR_W-1:0] word);
        return word[OPER_MSB:OPER_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-memory read port, IR valid/ready handshake and jump redirect
// between the fetch sequencer and its memory/execute neighbours.
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       ir;
    logic              ir_valid;
    logic              ir_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;

    modport master (
        output imem_en, imem_addr, ir, ir_valid,
        input  imem_rdata, ir_ready, jump_en, jump_addr
    );

    modport slave (
        input  imem_en, imem_addr, ir, ir_valid,
        output imem_rdata, ir_ready, jump_en, jump_addr
    );
endinterface

// File: rtl/instr_fetch.sv
// PC-driven instruction fetch sequencer: reads words from synchronous program
// memory and presents them as IR over valid/ready, handling jumps and HALT.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter logic [4:0] HALT_OP = OP_HALT
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              start,
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [IR_W-1:0]   ir_reg, ir_next;
    logic              ir_valid_reg, ir_valid_next;
    logic              halted_reg, halted_next;
    logic              handshake;

    assign handshake = (state_reg == FS_HOLD) && ir_valid_reg && bus.ir_ready;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_valid_next = ir_valid_reg;
        halted_next   = halted_reg;

        case (state_reg)
            FS_IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FS_FETCH;
                end
            end

            // A jump here re-issues the read at the new PC; the read launched
            // this cycle is overwritten by it before WAIT could use it.
            FS_FETCH: begin
                if (bus.jump_en) begin
                    pc_next    = bus.jump_addr;
                    state_next = FS_FETCH;
                end else begin
                    state_next = FS_WAIT;
                end
            end

            FS_WAIT: begin
                if (bus.jump_en) begin
                    pc_next       = bus.jump_addr;
                    ir_valid_next = 1'b0;
                    state_next    = FS_FETCH;
                end else if (ir_oper(bus.imem_rdata) == HALT_OP) begin
                    ir_next     = bus.imem_rdata;
                    halted_next = 1'b1;
                    state_next  = FS_HALTED;
                end else begin
                    ir_next       = bus.imem_rdata;
                    ir_valid_next = 1'b1;
                    state_next    = FS_HOLD;
                end
            end

            // Jump wins over pc+1 even when the consumer takes the word in
            // the same cycle; the handshake itself still completes.
            FS_HOLD: begin
                if (bus.jump_en) begin
                    pc_next       = bus.jump_addr;
                    ir_valid_next = 1'b0;
                    state_next    = FS_FETCH;
                end else if (handshake) begin
                    pc_next       = pc_reg + ADDR_W'(1);
                    ir_valid_next = 1'b0;
                    state_next    = FS_FETCH;
                end
            end

            FS_HALTED: begin
                if (start) begin
                    halted_next = 1'b0;
                    pc_next     = '0;
                    state_next  = FS_FETCH;
                end
            end

            default: begin
                state_next    = FS_IDLE;
                ir_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= FS_IDLE;
            pc_reg       <= '0;
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            halted_reg   <= halted_next;
        end
    end

    // The read strobe is a pure state decode so reset removes it immediately.
    assign bus.imem_en   = (state_reg == FS_FETCH);
    assign bus.imem_addr = pc_reg;
    assign bus.ir        = ir_reg;
    assign bus.ir_valid  = ir_valid_reg;
    assign pc            = pc_reg;
    assign halted        = halted_reg;

endmodule
